// File: rtl/main_arb_pkg.sv
// Shared definitions for the two-requester main-memory arbiter:
// FSM state encoding and default parameter values.
package main_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } arb_state_t;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/arb_timeout_ctr.sv
// BUSY-cycle watchdog for main_mem_arbiter; only instantiated when
// MAIN_ARB_TIMEOUT_EN is defined.
module arb_timeout_ctr
    import main_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires during the TIMEOUT-th enabled cycle so the FSM leaves BUSY on that edge.
    assign expired = enable && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter granting one of two requesters access to main memory.
// Optional BUSY watchdog enabled by defining MAIN_ARB_TIMEOUT_EN.
module main_mem_arbiter
    import main_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              rd1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              main_read,
    output logic              main_write,
    output logic [ADDR_W-1:0] main_addr,
    output logic [DATA_W-1:0] main_wdata,
    input  logic [DATA_W-1:0] main_rdata,
    input  logic              ready
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_owner;
    logic              r_wr;
    logic              r_prio;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_req0;
    logic              w_req1;
    logic              w_winner;
    logic              w_expired;
    logic              w_timeout;
    logic              w_finish;
    logic [DATA_W-1:0] w_capture;

    assign w_req0   = rd0 | wr0;
    assign w_req1   = rd1 | wr1;
    assign w_winner = (w_req0 && w_req1) ? r_prio : w_req1;

`ifdef MAIN_ARB_TIMEOUT_EN
    arb_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_ctr (
        .clk    (clk),
        .reset  (reset),
        .clear  (r_state != ST_BUSY),
        .enable (r_state == ST_BUSY),
        .expired(w_expired)
    );
`else
    localparam int unused_timeout = TIMEOUT;
    assign w_expired = 1'b0;
`endif

    // A ready arriving on the last allowed cycle still counts as success.
    assign w_timeout = w_expired && !ready;
    assign w_finish  = ready || w_expired;
    assign w_capture = w_timeout ? '0 : main_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        err0         = 1'b0;
        err1         = 1'b0;
        main_read    = 1'b0;
        main_write   = 1'b0;
        main_addr    = '0;
        main_wdata   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                gnt0       = !r_owner;
                gnt1       = r_owner;
                main_read  = !r_wr;
                main_write = r_wr;
                main_addr  = r_addr;
                main_wdata = r_wdata;
                if (w_finish) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                ack0         = !r_owner;
                ack1         = r_owner;
                err0         = !r_owner && r_err;
                err1         = r_owner && r_err;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner  <= 1'b0;
            r_wr     <= 1'b0;
            r_prio   <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req0 || w_req1) begin
                        // rd and wr together resolve to a write.
                        r_owner <= w_winner;
                        r_wr    <= w_winner ? wr1 : wr0;
                        r_addr  <= w_winner ? addr1 : addr0;
                        r_wdata <= w_winner ? wdata1 : wdata0;
                        r_err   <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (w_finish) begin
                        r_err <= w_timeout;
                        if (r_owner) begin
                            r_rdata1 <= w_capture;
                        end else begin
                            r_rdata0 <= w_capture;
                        end
                    end
                end
                ST_DONE: r_prio <= ~r_owner;
                default: ;
            endcase
        end
    end

    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Scoreboard bench for main_mem_arbiter: drivers queue expected transactions,
// a negedge monitor checks commands and acks against the queue head.
module tb_main_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
    logic [9:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        main_read, main_write;
    logic [9:0]  main_addr;
    logic [31:0] main_wdata;
    logic [31:0] main_rdata = '0;
    logic        ready = 1'b0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ready_lat = 0;
    bit          ready_always = 1'b0;
    int          busy_cnt = 0;

    typedef struct {
        bit          id;
        bit          wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    main_mem_arbiter #(
        .ADDR_W (10),
        .DATA_W (32),
        .TIMEOUT(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd0       (rd0),
        .wr0       (wr0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .rd1       (rd1),
        .wr1       (wr1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .err0      (err0),
        .err1      (err1),
        .main_read (main_read),
        .main_write(main_write),
        .main_addr (main_addr),
        .main_wdata(main_wdata),
        .main_rdata(main_rdata),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit id, input bit wr, input logic [9:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input bit er);
        exp_t e;
        e.id = id; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd; e.err = er;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input bit id, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if ((id ? ack1 : ack0) === 1'b1) break;
            if (n >= 200) begin
                chk($sformatf("ack%0d_wait_bound", id), 0, 1);
                break;
            end
        end
    endtask

    // Memory model: ready after ready_lat BUSY cycles (0 = never), or always.
    always @(negedge clk) begin
        if (main_read === 1'b1 || main_write === 1'b1) begin
            busy_cnt++;
            ready = ready_always || (ready_lat != 0 && busy_cnt == ready_lat);
        end else begin
            busy_cnt = 0;
            ready = ready_always;
        end
    end

    always @(negedge clk) begin
        if (main_read === 1'b1 || main_write === 1'b1) begin
            if (sb.size() == 0) begin
                chk("cmd_without_txn", 1, 0);
            end else begin
                mon_e = sb[0];
                chk("cmd_write", main_write, mon_e.wr);
                chk("cmd_read", main_read, !mon_e.wr);
                chk("cmd_addr", main_addr, mon_e.addr);
                if (mon_e.wr) chk("cmd_wdata", main_wdata, mon_e.wdata);
                chk("gnt_owner", mon_e.id ? gnt1 : gnt0, 1);
                chk("gnt_other", mon_e.id ? gnt0 : gnt1, 0);
            end
        end
        if (ack0 === 1'b1 || ack1 === 1'b1) begin
            if (sb.size() == 0) begin
                chk("ack_without_txn", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                $display("[TB] ack id=%0d wr=%0d addr=%0h rdata0=%0h rdata1=%0h err0=%0d err1=%0d",
                         ack1, mon_e.wr, mon_e.addr, rdata0, rdata1, err0, err1);
                chk("ack_id", ack1, mon_e.id);
                chk("ack_single", ack0 & ack1, 0);
                chk("ack_cmd_low", main_read | main_write, 0);
                if (!mon_e.wr) chk("ack_rdata", mon_e.id ? rdata1 : rdata0, mon_e.rdata);
                chk("ack_err", mon_e.id ? err1 : err0, mon_e.err);
                chk("ack_err_other", mon_e.id ? err0 : err1, 0);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {gnt0, gnt1}, 0);
        chk({tag, "_ack"}, {ack0, ack1}, 0);
        chk({tag, "_err"}, {err0, err1}, 0);
        chk({tag, "_cmd"}, {main_read, main_write}, 0);
        chk({tag, "_maddr"}, main_addr, 0);
        chk({tag, "_mwdata"}, main_wdata, 0);
        chk({tag, "_rdata0"}, rdata0, 0);
        chk({tag, "_rdata1"}, rdata1, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        apply_reset();

        // Single read, ready after 4 BUSY cycles.
        ready_lat = 4;
        main_rdata = 32'hDEADBEEF;
        push_exp(0, 0, 10'h015, 32'h0, 32'hDEADBEEF, 0);
        addr0 = 10'h015;
        rd0 = 1'b1;
        wait_ack(0, n);
        chk("read_latency", n, 5);
        rd0 = 1'b0;
        @(negedge clk);
        chk("rdata0_hold", rdata0, 32'hDEADBEEF);
        chk("rdata1_untouched", rdata1, 0);

        // Simultaneous read0 / write1 after reset: 0 first, then 1.
        apply_reset();
        ready_lat = 2;
        main_rdata = 32'h11112222;
        addr0 = 10'h101; addr1 = 10'h2F0; wdata1 = 32'hCAFEF00D;
        push_exp(0, 0, 10'h101, 32'h0, 32'h11112222, 0);
        push_exp(1, 1, 10'h2F0, 32'hCAFEF00D, 32'h0, 0);
        rd0 = 1'b1; wr1 = 1'b1;
        wait_ack(0, n);
        chk("dual_first_latency", n, 3);
        rd0 = 1'b0;
        wait_ack(1, n);
        chk("dual_second_latency", n, 4);
        wr1 = 1'b0;
        @(negedge clk);

        // Continuous requests with ready always high: strict alternation every 3 cycles.
        ready_always = 1'b1;
        main_rdata = 32'h0BADF00D;
        addr0 = 10'h033; addr1 = 10'h044; wdata1 = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            if ((k % 2) == 0) push_exp(0, 0, 10'h033, 32'h0, 32'h0BADF00D, 0);
            else              push_exp(1, 1, 10'h044, 32'h12345678, 32'h0, 0);
        end
        rd0 = 1'b1; wr1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(k[0], n);
            chk($sformatf("b2b_gap_%0d", k), n, (k == 0) ? 2 : 3);
        end
        rd0 = 1'b0; wr1 = 1'b0;
        ready_always = 1'b0;
        @(negedge clk);

        // Reset while requester 1 is BUSY: abandoned, then fresh contention goes to 0.
        ready_lat = 0;
        addr1 = 10'h3AA;
        push_exp(1, 0, 10'h3AA, 32'h0, 32'h0, 0);
        rd1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("busy_gnt1", gnt1, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        void'(sb.pop_front());
        rd1 = 1'b0;
        @(negedge clk);
        chk_all_zero("midbusy_reset");
        reset = 1'b0;
        @(negedge clk);
        ready_lat = 1;
        main_rdata = 32'h5555AAAA;
        addr0 = 10'h077; addr1 = 10'h088;
        push_exp(0, 0, 10'h077, 32'h0, 32'h5555AAAA, 0);
        push_exp(1, 0, 10'h088, 32'h0, 32'h5555AAAA, 0);
        rd0 = 1'b1; rd1 = 1'b1;
        wait_ack(0, n);
        chk("post_reset_first_latency", n, 2);
        rd0 = 1'b0;
        wait_ack(1, n);
        chk("post_reset_second_latency", n, 3);
        rd1 = 1'b0;
        @(negedge clk);

        // Memory never ready.
        ready_lat = 0;
        addr0 = 10'h2A0;
`ifdef MAIN_ARB_TIMEOUT_EN
        push_exp(0, 0, 10'h2A0, 32'h0, 32'h0, 1);
        rd0 = 1'b1;
        wait_ack(0, n);
        chk("timeout_latency", n, 9);
        rd0 = 1'b0;
        @(negedge clk);
`else
        push_exp(0, 0, 10'h2A0, 32'h0, 32'h0, 0);
        rd0 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("gnt0_held", gnt0, 1);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        void'(sb.pop_front());
        rd0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
`endif

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
